product_accumulator_valready: RTL

- Downstream consumer of the sequential array multiplier's valid/ready output port.
- Accepts a stream of signed products and sums a fixed number of consecutive products (NUM_TERMS) into one dot-product result.
- Presents that result on its own valid/ready output and holds it until the sink takes it.
- Applies back-pressure to the multiplier (prod_ready low) while a result is pending.

---
 rtl/product_accumulator_valready.sv | 60 ++++++
 1 files changed

// File: rtl/product_accumulator_valready.sv
// product_accumulator_valready: sums NUM_TERMS signed products into one valid/ready result (ACC_SATURATE_EN selects saturating adds)
module product_accumulator_valready #(
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_TERMS  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 prod_valid,
  output logic                                 prod_ready,
  input  logic signed [PROD_WIDTH-1:0]         product,
  output logic                                 acc_valid,
  input  logic                                 acc_ready,
  output logic signed [ACC_WIDTH-1:0]          acc_result,
  output logic [$clog2(NUM_TERMS+1)-1:0]       term_count
);
  localparam int CW = $clog2(NUM_TERMS+1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_next;
  logic signed [ACC_WIDTH-1:0] acc, ext, sum;
  logic prod_hs, res_hs, last;
  assign prod_ready = state != HOLD;
  assign acc_valid  = state == HOLD;
  assign prod_hs    = prod_valid && prod_ready;
  assign res_hs     = acc_valid && acc_ready;
  assign last       = term_count == CW'(NUM_TERMS-1);
  assign ext        = ACC_WIDTH'(product);
`ifdef ACC_SATURATE_EN
  logic signed [ACC_WIDTH-1:0] raw;
  logic ovf;
  assign raw = acc + ext;
  // overflow only when both operands share a sign the sum lacks
  assign ovf = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign sum = !ovf ? raw : acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign sum = acc + ext;
`endif
  always_comb begin
    state_next = state;
    state_next = state == HOLD ? (res_hs ? IDLE : HOLD) : (prod_hs ? (last ? HOLD : ACCUM) : state);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_result <= '0;
      term_count <= '0;
    end else if (res_hs) begin
      acc        <= '0;
      term_count <= '0;
    end else if (prod_hs) begin
      acc        <= sum;
      term_count <= term_count + 1'b1;
      if (last) acc_result <= sum;
    end
  end
endmodule
